// File: rtl/bp_pkg.sv
// Shared encodings and PC slicing helpers for the branch predictor.
// Counter states follow the classic 2-bit scheme; MSB set means "predict taken".
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CNT_RST = WNT;

    // Word-aligned index: pc[idx_bits+1:2]; callers truncate to their index width.
    function automatic logic [31:0] bp_idx(input logic [63:0] pc, input int idx_bits);
        return 32'((pc >> 2) & ((64'd1 << idx_bits) - 64'd1));
    endfunction

    function automatic logic [31:0] bp_tag(input logic [63:0] pc, input int idx_bits,
                                           input int tag_bits);
        return 32'((pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1));
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state function; alloc forces a fresh entry to WT.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    input  logic       alloc,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (alloc) begin
            nxt = WT;
        end else if (taken) begin
            if (cur != ST) nxt = cur + 2'd1;
        end else begin
            if (cur != SNT) nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + tagged BTB predictor; lookup is combinational, training at posedge.
// Define BP_STATS_EN to add saturating update/mispredict statistics outputs.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    output logic            upd_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int N = 1 << IDX_BITS;

    logic [1:0]          cnt_q [N];
    logic [1:0]          cnt_d [N];
    logic [N-1:0]        vld_q, vld_d;
    logic [TAG_BITS-1:0] tag_q [N];
    logic [TAG_BITS-1:0] tag_d [N];
    logic [XLEN-1:0]     tgt_q [N];
    logic [XLEN-1:0]     tgt_d [N];
    logic                mis_q, mis_d;

    logic [IDX_BITS-1:0] li, ui;
    logic [TAG_BITS-1:0] lt, ut;
    logic                lk_hit, upd_hit;
    logic [1:0]          cnt_nxt;

    assign li = IDX_BITS'(bp_idx(64'(if_pc), IDX_BITS));
    assign lt = TAG_BITS'(bp_tag(64'(if_pc), IDX_BITS, TAG_BITS));
    assign ui = IDX_BITS'(bp_idx(64'(upd_pc), IDX_BITS));
    assign ut = TAG_BITS'(bp_tag(64'(upd_pc), IDX_BITS, TAG_BITS));

    // Lookup reads only registered state, so a same-cycle update is not visible here.
    assign lk_hit      = vld_q[li] && (tag_q[li] == lt);
    assign pred_taken  = lk_hit && cnt_q[li][1];
    assign pred_target = pred_taken ? tgt_q[li] : if_pc + XLEN'(4);

    assign upd_hit = vld_q[ui] && (tag_q[ui] == ut);

    bp_sat_counter u_ctr (
        .cur  (cnt_q[ui]),
        .taken(upd_taken),
        .alloc(upd_taken && !upd_hit),
        .nxt  (cnt_nxt)
    );

    always_comb begin
        cnt_d = cnt_q;
        vld_d = vld_q;
        tag_d = tag_q;
        tgt_d = tgt_q;
        mis_d = upd_valid && (upd_taken != upd_pred_taken);
        if (upd_valid) begin
            if (upd_taken) begin
                cnt_d[ui] = cnt_nxt;
                vld_d[ui] = 1'b1;
                tag_d[ui] = ut;
                tgt_d[ui] = upd_target;
            end else if (upd_hit) begin
                cnt_d[ui] = cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= CNT_RST;
            vld_q <= '0;
            mis_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            mis_q <= mis_d;
        end
    end

    // Tags and targets are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    assign upd_mispredict = mis_q;

`ifdef BP_STATS_EN
    logic [31:0] su_q, su_d, sm_q, sm_d;

    always_comb begin
        su_d = su_q;
        sm_d = sm_q;
        if (upd_valid && su_q != '1) su_d = su_q + 32'd1;
        if (mis_d && sm_q != '1)     sm_d = sm_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            su_q <= '0;
            sm_q <= '0;
        end else begin
            su_q <= su_d;
            sm_q <= sm_d;
        end
    end

    assign stat_updates     = su_q;
    assign stat_mispredicts = sm_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed plan plus random traffic vs a table model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic        upd_mispredict;
`ifdef BP_STATS_EN
    logic [31:0] stat_updates, stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_pred_taken(upd_pred_taken),
        .upd_mispredict(upd_mispredict)
`ifdef BP_STATS_EN
        ,
        .stat_updates    (stat_updates),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    int nerr = 0;
    int nchk = 0;

    // Reference model: 64 entries, counter kept as a plain integer 0..3.
    int          m_cnt [64];
    bit          m_vld [64];
    int          m_tag [64];
    logic [31:0] m_tgt [64];
    bit          m_mis;
    longint      m_su, m_sm;

    function automatic int m_index(logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int m_tagof(logic [31:0] pc);
        return int'((pc / 256) % 256);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_vld[m_index(pc)] && m_tag[m_index(pc)] == m_tagof(pc);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_cnt[i] = 1;
            m_vld[i] = 0;
        end
        m_mis = 0;
        m_su  = 0;
        m_sm  = 0;
    endtask

    task automatic m_update(input bit uv, input logic [31:0] pc, input bit t,
                            input logic [31:0] tgt, input bit pt);
        int i;
        bit h;
        i = m_index(pc);
        h = m_hit(pc);
        m_mis = uv && (t != pt);
        if (uv) begin
            if (m_su < 64'hFFFF_FFFF) m_su++;
            if (t != pt && m_sm < 64'hFFFF_FFFF) m_sm++;
            if (t) begin
                m_cnt[i] = h ? ((m_cnt[i] == 3) ? 3 : m_cnt[i] + 1) : 2;
                m_vld[i] = 1;
                m_tag[i] = m_tagof(pc);
                m_tgt[i] = tgt;
            end else if (h) begin
                m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            end
        end
    endtask

    // One clock: lookup is checked before the edge (pre-update state), mispredict after.
    task automatic step(input bit r, input bit lk, input logic [31:0] lpc, input bit uv,
                        input logic [31:0] upc, input bit t, input logic [31:0] tgt,
                        input bit pt);
        bit          et;
        logic [31:0] etgt;
        rst = r; if_pc = lpc; upd_valid = uv; upd_pc = upc;
        upd_taken = t; upd_target = tgt; upd_pred_taken = pt;
        @(negedge clk);
        if (lk) begin
            et   = m_hit(lpc) && m_cnt[m_index(lpc)] >= 2;
            etgt = et ? m_tgt[m_index(lpc)] : lpc + 32'd4;
            chk("pred_taken", 32'(pred_taken), 32'(et));
            chk("pred_target", pred_target, etgt);
        end
        @(posedge clk);
        if (r) m_reset();
        else m_update(uv, upc, t, tgt, pt);
        #1;
        chk("upd_mispredict", 32'(upd_mispredict), 32'(m_mis));
`ifdef BP_STATS_EN
        chk("stat_updates", stat_updates, 32'(m_su));
        chk("stat_mispredicts", stat_mispredicts, 32'(m_sm));
`endif
    endtask

    task automatic look(input logic [31:0] lpc);
        step(0, 1, lpc, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic upd(input logic [31:0] lpc, input logic [31:0] upc, input bit t,
                       input logic [31:0] tgt, input bit pt);
        step(0, 1, lpc, 1, upc, t, tgt, pt);
    endtask

    function automatic logic [31:0] pool_pc();
        return 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'(256 * $urandom_range(0, 2));
    endfunction

    initial begin
        m_reset();
        step(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);

        // Cold table predicts fall-through everywhere.
        look(32'h100);
        chk("cold_taken", 32'(pred_taken), 32'd0);
        for (int k = 0; k < 8; k++) look($urandom & 32'hFFFF_FFFC);
        look(32'hFFFF_FFFC);

        // First taken update allocates at WT and flags the mispredict for one cycle.
        upd(32'h100, 32'h100, 1, 32'h80, 0);
        chk("alloc_mis", 32'(upd_mispredict), 32'd1);
        look(32'h100);
        chk("alloc_taken", 32'(pred_taken), 32'd1);
        chk("alloc_tgt", pred_target, 32'h80);
        chk("mis_clear", 32'(upd_mispredict), 32'd0);

        // Saturate up, walk down to WNT, then hold at SNT.
        for (int k = 0; k < 4; k++) upd(32'h100, 32'h100, 1, 32'h80, 1);
        for (int k = 0; k < 2; k++) upd(32'h100, 32'h100, 0, 32'h0, 1);
        look(32'h100);
        chk("wnt_taken", 32'(pred_taken), 32'd0);
        for (int k = 0; k < 5; k++) upd(32'h100, 32'h100, 0, 32'h0, 0);
        upd(32'h100, 32'h100, 1, 32'h80, 0);
        look(32'h100);
        chk("snt_floor", 32'(pred_taken), 32'd0);

        // Aliasing: same index, different tag.
        upd(32'h100, 32'h100, 1, 32'h80, 1);
        look(32'h200);
        chk("alias_miss", 32'(pred_taken), 32'd0);
        upd(32'h200, 32'h200, 1, 32'h40, 0);
        look(32'h100);
        chk("alias_evict", 32'(pred_taken), 32'd0);
        look(32'h200);
        chk("alias_new", pred_target, 32'h40);

        // Same-cycle lookup/update on a fresh entry.
        step(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        upd(32'h200, 32'h200, 1, 32'h1234, 0);
        look(32'h200);
        chk("bypass_next", pred_target, 32'h1234);

        // Reset wins over a concurrent update.
        step(1, 0, 32'h200, 1, 32'h300, 1, 32'h500, 0);
        look(32'h300);
        chk("rst_prio", 32'(pred_taken), 32'd0);
        upd(32'h300, 32'h300, 1, 32'h500, 1);
        upd(32'h300, 32'h300, 1, 32'h500, 0);
        upd(32'h300, 32'h300, 1, 32'h500, 1);
`ifdef BP_STATS_EN
        chk("stat_u3", stat_updates, 32'd3);
        chk("stat_m1", stat_mispredicts, 32'd1);
`endif

        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 59) == 0), 1, pool_pc(), 1'($urandom_range(0, 1)),
                 pool_pc(), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
